hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller; the producing end of the PC stall interface.
- Generates the PC hold (hazard_pc_o), the IF/ID stall and flush, and the ID/EX bubble.
- Detects load-use hazards, holds the front end for a multi-cycle multiply, and squashes the fetched instruction on a taken branch.
- Sits beside the ID stage. Drives the PC register, the IF/ID register and the ID/EX control mux. Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MUL_LAT, 4, total cycles a multiply occupies ID/EX; legal range 2..15.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- start_i  in  1  core run enable; low forces idle, no hazards reported.
- idex_memread_i  in  1  instruction in EX is a load.
- idex_rt_i  in  5  destination register of the instruction in EX.
- ifid_rs_i  in  5  rs of the instruction in ID.
- ifid_rt_i  in  5  rt of the instruction in ID.
- ifid_mul_i  in  1  instruction in ID is a multiply.
- branch_taken_i  in  1  branch in ID resolved taken this cycle.
- hazard_pc_o  out  1  hold PC (PC keeps its value when high).
- ifid_stall_o  out  1  hold the IF/ID register.
- ifid_flush_o  out  1  zero the IF/ID register (insert NOP).
- idex_bubble_o  out  1  zero the ID/EX control fields.
- mul_busy_o  out  1  multiply sequence in progress.
- stall_cnt_o  out  CNT_W  count of cycles with hazard_pc_o high; saturates.

Behaviour:
- Reset (rst_i low at a clock edge): state=RUN, mul counter=0, stall_cnt_o=0. Reset mid-multiply abandons the sequence; the next cycle is RUN.
- Reset values of the combinational outputs: all 0 while rst_i is low.
- Load-use hazard, combinational: lu = idex_memread_i & (idex_rt_i != 0) & ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i)).
- States: RUN, MUL.
- RUN, start_i low: every output 0; stays in RUN; counter does not increment.
- RUN, lu=1:
  - hazard_pc_o=1, ifid_stall_o=1, idex_bubble_o=1, ifid_flush_o=0.
  - Exactly one stall cycle per load, because the bubble clears idex_memread_i the next cycle.
  - Load-use has priority over multiply start and over branch_taken_i; both are ignored this cycle and re-evaluated once the ID instruction is unstalled.
- RUN, lu=0, ifid_mul_i=1:
  - Transition to MUL with cnt=MUL_LAT-2.
  - This cycle: no stall, so the multiply advances into EX.
  - mul_busy_o goes high from the next cycle.
- RUN, lu=0, ifid_mul_i=0, branch_taken_i=1: ifid_flush_o=1 for this cycle only; no PC hold.
- MUL:
  - hazard_pc_o=1, ifid_stall_o=1, idex_bubble_o=1, mul_busy_o=1.
  - cnt decrements each cycle.
  - When cnt==0, return to RUN at the next edge.
  - The front end is held for MUL_LAT-1 cycles in total.
  - branch_taken_i and lu are ignored in MUL.
- start_i dropping in MUL: the sequence completes; start_i is only sampled in RUN.
- Flush and stall are never both high in one cycle.
- Stall counter:
  - stall_cnt_o increments at the edge after any cycle with hazard_pc_o=1.
  - Holds at all-ones; no wrap-around.
  - Registered output, so it lags hazard_pc_o by one cycle.
- hazard_pc_o/ifid_stall_o/idex_bubble_o/ifid_flush_o are combinational from state and inputs, with no extra latency. mul_busy_o and stall_cnt_o are registered.

Decomposition:
- Shared pipeline package:
  - State encoding (RUN=1'b0, MUL=1'b1).
  - REG_ZERO=5'd0 constant.
  - Default MUL_LAT, shared with the multiplier datapath so both agree on latency.
- One natural sub-module: hazard_stall_cnt, the saturating CNT_W-bit counter with synchronous active-low reset.
- Load-use compare and FSM stay inline.

Test Plan:
- Reset: rst_i=0 for 2 cycles during MUL -> next cycle all outputs 0, stall_cnt_o=0, state RUN.
- Load-use: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 for one cycle -> hazard_pc_o=ifid_stall_o=idex_bubble_o=1 that cycle only; stall_cnt_o=1 the next cycle.
  - Repeat with idex_rt_i=0 -> no stall.
  - Repeat with the match on ifid_rt_i -> stall.
- Multiply, MUL_LAT=4: ifid_mul_i=1 in RUN -> no stall that cycle, then exactly 3 cycles of hazard_pc_o=1 and mul_busy_o=1, then RUN; stall_cnt_o advances by 3.
- Simultaneous lu=1 and branch_taken_i=1 -> stall asserted, ifid_flush_o=0. Next cycle with lu=0 and branch_taken_i=1 -> ifid_flush_o=1 for exactly one cycle.
- start_i=0 with lu conditions true -> all outputs 0. Set start_i=0 in MUL -> sequence still completes its MUL_LAT-1 stall cycles.
- Saturation, CNT_W=4: hold in repeated load-use for 20 stall cycles -> stall_cnt_o reaches 15 and stays at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller and the multiplier datapath.
// Both sides take their multiply latency from MUL_LAT_DEF so they cannot disagree.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         MUL_LAT_DEF = 4;
    localparam int         MUL_CNT_W   = 4;

endpackage

// File: rtl/hazard_stall_cnt.sv
// Saturating stall-cycle counter for performance debug; holds at all-ones.
module hazard_stall_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle multiply hold and
// taken-branch squash of the IF/ID register, plus a saturating stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_mul_i,
    input  logic             branch_taken_i,
    output logic             hazard_pc_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             mul_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    hz_state_e            state_q, state_d;
    logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic                 mul_busy_p1;
    logic                 lu;

    assign lu = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    // Stage 0: next state and combinational hazard controls.
    // The multiply itself advances into EX in the RUN cycle, so MUL only
    // needs MUL_LAT-1 held cycles, counted down from MUL_LAT-2 to 0.
    always_comb begin
        state_d       = state_q;
        mul_cnt_d     = mul_cnt_q;
        hazard_pc_o   = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        if (rst_i) begin
            case (state_q)
                RUN: begin
                    if (start_i) begin
                        if (lu) begin
                            hazard_pc_o   = 1'b1;
                            ifid_stall_o  = 1'b1;
                            idex_bubble_o = 1'b1;
                        end else if (ifid_mul_i) begin
                            state_d   = MUL;
                            mul_cnt_d = MUL_CNT_W'(MUL_LAT - 2);
                        end else if (branch_taken_i) begin
                            ifid_flush_o = 1'b1;
                        end
                    end
                end
                MUL: begin
                    hazard_pc_o   = 1'b1;
                    ifid_stall_o  = 1'b1;
                    idex_bubble_o = 1'b1;
                    if (mul_cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Stage 1: registered FSM state and busy flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            mul_cnt_q   <= '0;
            mul_busy_p1 <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_cnt_q   <= mul_cnt_d;
            mul_busy_p1 <= (state_d == MUL);
        end
    end

    assign mul_busy_o = mul_busy_p1;

    hazard_stall_cnt #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inc_i(hazard_pc_o),
        .cnt_o(stall_cnt_o)
    );

endmodule
